// File: rtl/gray_pkg.sv
// Shared definitions for the grayscale frame datapath: sequencer state
// encoding, converter rounding-mode codes and the ROM+converter latency.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;

  // ROM registers the pixel, then the converter registers the gray value.
  localparam int unsigned PIPE_LAT = 2;

endpackage

// File: rtl/gray_pipe_track.sv
// Valid/address delay line that follows each ROM read through the
// ROM+converter pipeline so the write into the frame RAM lines up with
// the converter output. A synchronous flush drops all in-flight valids.
module gray_pipe_track #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  // Shift {valid, addr} one stage per cycle; flush clears every valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid & ~flush;
      addr_q[0]  <= in_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush;
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the ROM -> grayscale -> RAM datapath. Sweeps the
// pixel addresses, holds the rounding mode for the frame and issues
// pipeline-aligned RAM writes.
// Optional feature: define GRAY_CHECKSUM_EN to add the checksum output,
// a running sum of every gray value written to the frame RAM.
module gray_frame_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = 16384,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode_in,
  input  logic [7:0]          gray_in,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [1:0]          gray_mode,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                busy,
  output logic                done
`ifdef GRAY_CHECKSUM_EN
  ,
  output logic [ADDR_W+7:0]   checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_d;
  logic              drain_q, drain_d;
  logic [1:0]        mode_d;
  logic              rom_en_d, busy_d, done_d;
  logic              accept;

  assign accept = (state_q == IDLE) && start && !abort;

  // Next-state, counter and next-output decode; outputs are registered
  // from the next-state values so every control output comes off a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = rom_addr;
    drain_d = drain_q;
    mode_d  = gray_mode;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = READ;
          cnt_d   = '0;
          mode_d  = mode_in;
        end
      end
      READ: begin
        if (rom_addr == LAST_ADDR) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          cnt_d = rom_addr + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = rom_addr;
    end
    rom_en_d = (state_d == READ);
    busy_d   = (state_d == READ) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_q   <= 1'b0;
      rom_addr  <= '0;
      gray_mode <= '0;
      rom_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      rom_addr  <= cnt_d;
      gray_mode <= mode_d;
      rom_en    <= rom_en_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  gray_pipe_track #(
    .ADDR_W (ADDR_W),
    .DEPTH  (PIPE_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .in_valid  (rom_en),
    .in_addr   (rom_addr),
    .out_valid (ram_we),
    .out_addr  (ram_addr)
  );

  assign ram_wdata = gray_in;

`ifdef GRAY_CHECKSUM_EN
  // Sum of written gray values; cleared on an accepted start, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (ram_we) begin
      checksum <= checksum + (ADDR_W+8)'(ram_wdata);
    end
  end
`endif

endmodule

// File: tb/tb_gray_frame_ctrl.sv
module tb_gray_frame_ctrl;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [1:0]    mode_in;
  logic [7:0]    gray_in;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [1:0]    gray_mode;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          busy;
  logic          done;
`ifdef GRAY_CHECKSUM_EN
  logic [AW+7:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pix [8];
  logic [7:0] rom_q;

  gray_frame_ctrl #(
    .NUM_PIXELS (N),
    .ADDR_W     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode_in   (mode_in),
    .gray_in   (gray_in),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .gray_mode (gray_mode),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done)
`ifdef GRAY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: registered ROM followed by a registered converter stage.
  always @(posedge clk) begin
    if (rom_en) rom_q <= pix[rom_addr];
    gray_in <= rom_q;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_en"},    32'(rom_en),    32'd0);
    check({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
    check({tag, "_gray_mode"}, 32'(gray_mode), 32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
`ifdef GRAY_CHECKSUM_EN
    check({tag, "_checksum"},  32'(checksum),  32'd0);
`endif
  endtask

  // Expected behaviour per cycle c after the accepting edge, from the
  // frame timing rules: reads in 1..N, writes in 3..N+2, done at N+3;
  // an abort sampled at the end of cycle a silences everything after a.
  task automatic run_frame(input logic [1:0] mode, input int abort_at, input bit start_busy);
    bit   alive;
    int   sum;
    sum     = 0;
    start   = 1'b1;
    mode_in = mode;
    @(posedge clk); #1;
    start   = 1'b0;
    mode_in = 2'($urandom);
    for (int c = 1; c <= N + 4; c++) begin
      alive = (abort_at == 0) || (c <= abort_at);
      check("busy",      32'(busy),      32'(alive && c <= N + 2));
      check("rom_en",    32'(rom_en),    32'(alive && c <= N));
      check("ram_we",    32'(ram_we),    32'(alive && c >= 3 && c <= N + 2));
      check("done",      32'(done),      32'(alive && c == N + 3));
      check("gray_mode", 32'(gray_mode), 32'(mode));
      if (alive && c <= N) check("rom_addr", 32'(rom_addr), 32'(c - 1));
`ifdef GRAY_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(sum));
`endif
      if (alive && c >= 3 && c <= N + 2) begin
        check("ram_addr",  32'(ram_addr),  32'(c - 3));
        check("ram_wdata", 32'(ram_wdata), 32'(pix[c-3]));
        sum += int'(pix[c-3]);
      end
      abort = (c == abort_at);
      if (start_busy && c == 2) begin
        start   = 1'b1;
        mode_in = 2'b01;
      end else begin
        start = 1'b0;
      end
      if ((abort_at != 0 && c == abort_at + 1) || c == N + 4) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic rand_pix();
    for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode_in = 2'b00;
    for (int i = 0; i < 8; i++) pix[i] = 8'd0;
    #1;
    check_reset_vals("reset");
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort alone and start together with abort are both ignored in IDLE.
    abort = 1'b1;
    @(posedge clk); #1;
    check("idle_abort_busy", 32'(busy), 32'd0);
    start   = 1'b1;
    mode_in = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy",   32'(busy),      32'd0);
    check("start_abort_rom_en", 32'(rom_en),    32'd0);
    check("start_abort_mode",   32'(gray_mode), 32'd0);

    // Basic frame, mode EVEN.
    rand_pix();
    run_frame(2'b10, 0, 1'b0);
    // Start while busy is ignored.
    rand_pix();
    run_frame(2'b10, 0, 1'b1);
    // All-white pixels.
    for (int i = 0; i < N; i++) pix[i] = 8'd255;
    run_frame(2'b00, 0, 1'b0);
    // Abort in cycle 3, then a new start in cycle 4.
    rand_pix();
    run_frame(2'b10, 3, 1'b0);
    rand_pix();
    run_frame(2'b01, 0, 1'b0);
    // Known values for the running sum.
    pix[0] = 8'd10; pix[1] = 8'd20; pix[2] = 8'd30; pix[3] = 8'd40;
    run_frame(2'b00, 0, 1'b0);
`ifdef GRAY_CHECKSUM_EN
    @(posedge clk); #1;
    check("checksum_hold", 32'(checksum), 32'd100);
`endif

    // Randomized frames: mode, pixels, abort point and start-while-busy.
    for (int f = 0; f < 24; f++) begin
      rand_pix();
      run_frame(2'($urandom_range(0, 2)),
                ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, N + 2)),
                1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("idle_gap_busy", 32'(busy), 32'd0);
      end
    end

    // Reset in cycle 2 clears outputs without waiting for an edge.
    rand_pix();
    start   = 1'b1;
    mode_in = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    // Sequencer still works after the mid-frame reset.
    rand_pix();
    run_frame(2'b01, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
